// File: rtl/common_pkg.sv
// ============================================================================
// Module : common_pkg
// Brief  : Shared LUT geometry for the log-sum-exp adder and the loader state
//          enum. CHECK only exists when LSE_LUT_CHECKSUM_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package common_pkg;

  localparam int LUT_SIZE      = 16;
  localparam int LUT_PRECISION = 10;

`ifdef LSE_LUT_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } lut_ld_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd3
  } lut_ld_state_e;
`endif

endpackage

`default_nettype wire

// File: rtl/lse_lut_loader_lut_bank.sv
// ============================================================================
// Module : lut_bank
// Brief  : One LUT register array with a single-entry write port, a bulk copy
//          port and a parallel output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lut_bank #(
  parameter int p_depth  = 16,
  parameter int p_width  = 10,
  parameter int p_addr_w = $clog2(p_depth)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [p_addr_w-1:0] i_addr,
  input  logic [p_width-1:0]  i_wdata,
  input  logic                i_bulk_we,
  input  logic [p_width-1:0]  i_bulk_data [p_depth],
  output logic [p_width-1:0]  o_data      [p_depth]
);

  logic [p_width-1:0] r_mem [p_depth];

  // A bulk copy takes priority so a commit always lands as a whole table.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < p_depth; i++) r_mem[i] <= '0;
    end else if (i_bulk_we) begin
      r_mem <= i_bulk_data;
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_data = r_mem;

endmodule

`default_nettype wire

// File: rtl/lse_lut_loader.sv
// ============================================================================
// Module : lse_lut_loader
// Brief  : Streams LUT entries into a shadow bank and commits them atomically
//          to the active bank feeding the log-sum-exp adder.
//          Optional checksum beat: define LSE_LUT_CHECKSUM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lse_lut_loader
  import common_pkg::*;
#(
  parameter int p_lut_size      = LUT_SIZE,
  parameter int p_lut_precision = LUT_PRECISION
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_load_start,
  input  logic                          i_wr_valid,
  input  logic [p_lut_precision-1:0]    i_wr_data,
  output logic                          o_wr_ready,
  output logic [p_lut_precision-1:0]    o_lut_table [p_lut_size],
  output logic                          o_lut_valid,
  output logic                          o_busy,
  output logic                          o_load_done,
  output logic                          o_error,
  input  logic [$clog2(p_lut_size)-1:0] i_rd_addr,
  output logic [p_lut_precision-1:0]    o_rd_data
);

  localparam int                 c_idx_w    = $clog2(p_lut_size);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(p_lut_size - 1);

  lut_ld_state_e              r_state;
  logic [c_idx_w-1:0]         r_idx;
  logic                       r_commit_pend;
  logic [p_lut_precision-1:0] w_shadow_tbl [p_lut_size];
  logic                       w_beat;
  logic                       w_last;
  logic                       w_shadow_we;

`ifdef LSE_LUT_CHECKSUM_EN
  logic [p_lut_precision-1:0] r_xor;
  assign o_wr_ready = (r_state == ST_LOAD) || (r_state == ST_CHECK);
`else
  assign o_wr_ready = (r_state == ST_LOAD);
  assign o_error    = 1'b0;
`endif

  assign o_busy      = (r_state != ST_IDLE);
  assign w_beat      = i_wr_valid && o_wr_ready;
  assign w_last      = (r_idx == c_last_idx);
  // A restart in the same cycle as a beat drops the beat.
  assign w_shadow_we = (r_state == ST_LOAD) && w_beat && !i_load_start;
  assign o_rd_data   = o_lut_table[i_rd_addr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_commit_pend <= 1'b0;
      o_lut_valid   <= 1'b0;
      o_load_done   <= 1'b0;
`ifdef LSE_LUT_CHECKSUM_EN
      r_xor         <= '0;
      o_error       <= 1'b0;
`endif
    end else begin
      r_commit_pend <= 1'b0;
      o_load_done   <= r_commit_pend;
      if (r_commit_pend) o_lut_valid <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_load_start) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
`ifdef LSE_LUT_CHECKSUM_EN
            r_xor   <= '0;
            o_error <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (i_load_start) begin
            r_idx <= '0;
`ifdef LSE_LUT_CHECKSUM_EN
            r_xor <= '0;
`endif
          end else if (w_beat) begin
`ifdef LSE_LUT_CHECKSUM_EN
            r_xor <= r_xor ^ i_wr_data;
`endif
            if (w_last) begin
`ifdef LSE_LUT_CHECKSUM_EN
              r_state <= ST_CHECK;
`else
              r_state <= ST_COMMIT;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
`ifdef LSE_LUT_CHECKSUM_EN
        ST_CHECK: begin
          if (i_load_start) begin
            r_state <= ST_LOAD;
            r_idx   <= '0;
            r_xor   <= '0;
          end else if (w_beat) begin
            if (i_wr_data == r_xor) begin
              r_state <= ST_COMMIT;
            end else begin
              o_error <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
`endif
        ST_COMMIT: begin
          // Copy is issued one edge later so the new table appears together
          // with o_load_done and o_lut_valid.
          r_commit_pend <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  lut_bank #(
    .p_depth (p_lut_size),
    .p_width (p_lut_precision)
  ) u_shadow (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_we        (w_shadow_we),
    .i_addr      (r_idx),
    .i_wdata     (i_wr_data),
    .i_bulk_we   (1'b0),
    .i_bulk_data (o_lut_table),
    .o_data      (w_shadow_tbl)
  );

  lut_bank #(
    .p_depth (p_lut_size),
    .p_width (p_lut_precision)
  ) u_active (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_we        (1'b0),
    .i_addr      ('0),
    .i_wdata     ('0),
    .i_bulk_we   (r_commit_pend),
    .i_bulk_data (w_shadow_tbl),
    .o_data      (o_lut_table)
  );

endmodule

`default_nettype wire
